gol_ctrl_fsm: RTL
=================

Name: gol_ctrl_fsm

Overview:
- Parametrised Game-of-Life control FSM, successor to the fixed 128-cell, 2-bit controller.
- Sequences IDLE/PROGRAM/RUN/PAUSE, owns the programming cursor and generates cell write strobes.
- Paces generations with a tick divider, handshakes each generation with the update engine, and counts generations.
- Sits between the board buttons and the cell-array/update engine.

Parameters:
- ROWS, 8, grid rows.
- COLS, 16, grid columns; N = ROWS*COLS cells.
- IDX_W, 7, cell_idx width; must satisfy 2^IDX_W >= N.
- GEN_W, 16, generation counter width.
- TICK_DIV, 1000, clka cycles between generation starts in RUN; minimum 2.

Ports:
- clka  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- stop  in  1  level; return to IDLE.
- prgm  in  1  IDLE: enter PROGRAM. PROGRAM: cursor back one.
- pp  in  1  play/pause.
- btn0  in  1  PROGRAM: write 0 at cursor, advance.
- btn1  in  1  PROGRAM: write 1 at cursor, advance.
- step_done  in  1  one-cycle pulse from update engine: generation committed.
- cell_idx  out  IDX_W  programming cursor.
- cell_we  out  1  one-cycle cell write strobe.
- cell_wdata  out  1  value written when cell_we=1.
- step_start  out  1  one-cycle pulse: engine computes one generation.
- game_state  out  2  00 IDLE, 01 PROGRAM, 10 RUN, 11 PAUSE.
- gen_count  out  GEN_W  generations completed.

Behaviour:
- Clock and reset: clka is the only clock. rst is synchronous, active-high.
- Reset values: state IDLE; cell_idx 0; cell_we 0; cell_wdata 0; step_start 0; game_state 00; gen_count 0; tick counter 0; all edge-detect registers 0; stop_pend 0.
- rst overrides every other input, including mid-STEP.
- Edge detection: prgm, pp, btn0, btn1 act only on a rising edge (in=1 while registered previous value=0). Holding a button produces one event.
- Latency: all outputs are registered; the response appears the cycle after the qualifying edge is sampled.
- Internal states: IDLE, PROGRAM, RUN, STEP, PAUSE. STEP reports game_state=10.
- IDLE:
  - prgm edge -> PROGRAM; cell_idx=0, gen_count=0.
- PROGRAM:
  - btn0 edge alone -> cell_we=1, cell_wdata=0 at the current cell_idx; cell_idx+1 next cycle.
  - btn1 edge alone -> same, with cell_wdata=1.
  - btn0 and btn1 edges in the same cycle -> ignored, no write.
  - prgm edge -> cell_idx-1. A simultaneous btn edge takes priority over prgm.
  - Wrap: increment from N-1 goes to 0; decrement from 0 goes to N-1. Values >= N are never produced.
  - pp edge -> RUN; tick counter=0. A pp edge outranks a btn/prgm edge in the same cycle.
- RUN:
  - Tick counter increments each cycle. At TICK_DIV-1: step_start=1 for one cycle, counter=0, -> STEP.
  - pp edge -> PAUSE; tick counter holds.
- STEP:
  - Waits for step_done, then gen_count+1 (wraps at 2^GEN_W-1 -> 0).
  - Next state after step_done: PAUSE if a pp edge was latched during STEP, else RUN.
  - A pp edge during STEP is latched, not acted on immediately.
  - No timeout.
- PAUSE:
  - pp edge -> RUN; tick counter resumes from its held value.
- stop (level, sampled every cycle):
  - In IDLE, PROGRAM, RUN or PAUSE: next state IDLE, cell_idx=0, step_start/cell_we deasserted. gen_count holds until the next PROGRAM entry.
  - In STEP: stop_pend=1; the FSM goes to IDLE on step_done so the grid is never torn. gen_count still increments for that generation.
  - stop and a prgm edge in the same cycle: stop wins.
- cell_we only in PROGRAM; step_start only on the RUN->STEP transition (or a single step, below).

Optional Feature:
- Macro GOL_SINGLE_STEP_EN.
- When defined: in PAUSE, a btn1 edge issues step_start and enters STEP. After step_done, return to PAUSE (not RUN), gen_count+1. A pp edge during that STEP resumes RUN after step_done.
- When undefined: btn0/btn1 have no effect in PAUSE, and the STEP-return logic omits the single-step flag.

Test Plan:
- rst held 2 cycles mid-RUN -> game_state=00, cell_idx=0, gen_count=0, step_start=0 the cycle after.
- IDLE, prgm edge; btn1 x3, btn0 x1 -> writes idx0=1, idx1=1, idx2=1, idx3=0; cell_idx=4. Then prgm edge -> cell_idx=3.
- PROGRAM at cell_idx=0, prgm edge -> cell_idx=127 (ROWS=8, COLS=16). Then btn1 -> write at 127, cell_idx=0. btn0 and btn1 edges in the same cycle -> no cell_we.
- TICK_DIV=4, pp edge from PROGRAM; engine answers step_done 3 cycles after each step_start -> step_start exactly 4 cycles after RUN entry; gen_count=1, then 2 after the second.
- stop asserted in STEP, step_done 5 cycles later -> game_state stays 10 until step_done, then 00; gen_count incremented by 1; no further step_start.
- GOL_SINGLE_STEP_EN: PAUSE, btn1 edge -> one step_start; after step_done, game_state=11, gen_count+1. Macro undefined: btn1 in PAUSE -> no step_start.

Source files
------------

// File: rtl/gol_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// gol_ctrl_fsm : Game-of-Life controller - programming cursor, generation
//                pacing and update-engine handshake.
// Optional macro GOL_SINGLE_STEP_EN: btn1 in PAUSE runs one generation.
// Revision 1.0
// ============================================================================
module gol_ctrl_fsm #(
    parameter int ROWS     = 8,
    parameter int COLS     = 16,
    parameter int IDX_W    = 7,
    parameter int GEN_W    = 16,
    parameter int TICK_DIV = 1000
) (
    input  logic             clka,
    input  logic             rst,
    input  logic             stop,
    input  logic             prgm,
    input  logic             pp,
    input  logic             btn0,
    input  logic             btn1,
    input  logic             step_done,
    output logic [IDX_W-1:0] cell_idx,
    output logic             cell_we,
    output logic             cell_wdata,
    output logic             step_start,
    output logic [1:0]       game_state,
    output logic [GEN_W-1:0] gen_count
);
    localparam int N      = ROWS * COLS;
    localparam int TICK_W = $clog2(TICK_DIV);

    localparam logic [IDX_W-1:0]  C_IDX_LAST  = IDX_W'(N - 1);
    localparam logic [TICK_W-1:0] C_TICK_LAST = TICK_W'(TICK_DIV - 1);

    localparam logic [1:0] GS_IDLE    = 2'b00;
    localparam logic [1:0] GS_PROGRAM = 2'b01;
    localparam logic [1:0] GS_RUN     = 2'b10;
    localparam logic [1:0] GS_PAUSE   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PROGRAM = 3'd1,
        S_RUN     = 3'd2,
        S_STEP    = 3'd3,
        S_PAUSE   = 3'd4
    } state_t;

    state_t            state_q;
    logic              prgm_q, pp_q, btn0_q, btn1_q;
    logic [TICK_W-1:0] tick_q;
    logic              stop_pend_q;
    logic              pp_pend_q;
    logic [IDX_W-1:0]  cell_idx_q;
    logic              cell_we_q;
    logic              cell_wdata_q;
    logic              step_start_q;
    logic [1:0]        game_state_q;
    logic [GEN_W-1:0]  gen_count_q;
`ifdef GOL_SINGLE_STEP_EN
    logic              single_q;
`endif

    logic             prgm_e, pp_e, btn0_e, btn1_e;
    logic             pp_seen;
    logic             step_to_pause;
    logic [IDX_W-1:0] idx_base;
    logic [IDX_W-1:0] idx_dec;

    assign prgm_e = prgm & ~prgm_q;
    assign pp_e   = pp   & ~pp_q;
    assign btn0_e = btn0 & ~btn0_q;
    assign btn1_e = btn1 & ~btn1_q;

    // The cursor shows the write address during the strobe and advances one cycle later.
    assign idx_base = cell_we_q ? ((cell_idx_q == C_IDX_LAST) ? '0 : cell_idx_q + IDX_W'(1))
                                : cell_idx_q;
    assign idx_dec  = (idx_base == '0) ? C_IDX_LAST : idx_base - IDX_W'(1);

    assign pp_seen = pp_pend_q | pp_e;
`ifdef GOL_SINGLE_STEP_EN
    assign step_to_pause = pp_seen ^ single_q;
`else
    assign step_to_pause = pp_seen;
`endif

    always_ff @(posedge clka) begin
        if (rst) begin
            state_q      <= S_IDLE;
            game_state_q <= GS_IDLE;
            prgm_q       <= 1'b0;
            pp_q         <= 1'b0;
            btn0_q       <= 1'b0;
            btn1_q       <= 1'b0;
            tick_q       <= '0;
            stop_pend_q  <= 1'b0;
            pp_pend_q    <= 1'b0;
            cell_idx_q   <= '0;
            cell_we_q    <= 1'b0;
            cell_wdata_q <= 1'b0;
            step_start_q <= 1'b0;
            gen_count_q  <= '0;
`ifdef GOL_SINGLE_STEP_EN
            single_q     <= 1'b0;
`endif
        end else begin
            prgm_q       <= prgm;
            pp_q         <= pp;
            btn0_q       <= btn0;
            btn1_q       <= btn1;
            cell_we_q    <= 1'b0;
            step_start_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (!stop && prgm_e) begin
                        state_q      <= S_PROGRAM;
                        game_state_q <= GS_PROGRAM;
                        cell_idx_q   <= '0;
                        gen_count_q  <= '0;
                    end
                end

                S_PROGRAM: begin
                    cell_idx_q <= idx_base;
                    if (stop) begin
                        state_q      <= S_IDLE;
                        game_state_q <= GS_IDLE;
                        cell_idx_q   <= '0;
                    end else if (pp_e) begin
                        state_q      <= S_RUN;
                        game_state_q <= GS_RUN;
                        tick_q       <= '0;
                    end else if (btn0_e ^ btn1_e) begin
                        cell_we_q    <= 1'b1;
                        cell_wdata_q <= btn1_e;
                    end else if (prgm_e && !btn0_e && !btn1_e) begin
                        cell_idx_q   <= idx_dec;
                    end
                end

                S_RUN: begin
                    if (stop) begin
                        state_q      <= S_IDLE;
                        game_state_q <= GS_IDLE;
                        cell_idx_q   <= '0;
                    end else if (pp_e) begin
                        state_q      <= S_PAUSE;
                        game_state_q <= GS_PAUSE;
                    end else if (tick_q == C_TICK_LAST) begin
                        state_q      <= S_STEP;
                        tick_q       <= '0;
                        step_start_q <= 1'b1;
                    end else begin
                        tick_q       <= tick_q + TICK_W'(1);
                    end
                end

                // Stop and pause requests wait for the engine so a generation is never torn.
                S_STEP: begin
                    if (step_done) begin
                        gen_count_q <= gen_count_q + GEN_W'(1);
                        stop_pend_q <= 1'b0;
                        pp_pend_q   <= 1'b0;
`ifdef GOL_SINGLE_STEP_EN
                        single_q    <= 1'b0;
`endif
                        if (stop || stop_pend_q) begin
                            state_q      <= S_IDLE;
                            game_state_q <= GS_IDLE;
                            cell_idx_q   <= '0;
                        end else if (step_to_pause) begin
                            state_q      <= S_PAUSE;
                            game_state_q <= GS_PAUSE;
                        end else begin
                            state_q      <= S_RUN;
                            game_state_q <= GS_RUN;
                        end
                    end else begin
                        if (stop) begin
                            stop_pend_q <= 1'b1;
                        end
                        if (pp_e) begin
                            pp_pend_q <= 1'b1;
                        end
                    end
                end

                S_PAUSE: begin
                    if (stop) begin
                        state_q      <= S_IDLE;
                        game_state_q <= GS_IDLE;
                        cell_idx_q   <= '0;
                    end else if (pp_e) begin
                        state_q      <= S_RUN;
                        game_state_q <= GS_RUN;
`ifdef GOL_SINGLE_STEP_EN
                    end else if (btn1_e) begin
                        state_q      <= S_STEP;
                        game_state_q <= GS_RUN;
                        step_start_q <= 1'b1;
                        single_q     <= 1'b1;
`endif
                    end
                end

                default: begin
                    state_q      <= S_IDLE;
                    game_state_q <= GS_IDLE;
                    cell_idx_q   <= '0;
                end
            endcase
        end
    end

    assign cell_idx   = cell_idx_q;
    assign cell_we    = cell_we_q;
    assign cell_wdata = cell_wdata_q;
    assign step_start = step_start_q;
    assign game_state = game_state_q;
    assign gen_count  = gen_count_q;

endmodule
`default_nettype wire
